// File: rtl/rca_result_collector.sv
// ============================================================================
// Module   : rca_result_collector
// Purpose  : Pairs in-order slot results with issued instruction IDs and
//            presents tagged results to writeback over a valid/ack handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rca_result_collector #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int ID_W  = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [ID_W-1:0]  issue_id,
    output logic             issue_ready,
    input  logic             result_valid,
    input  logic [XLEN-1:0]  result_data,
    output logic             wb_valid,
    output logic [ID_W-1:0]  wb_id,
    output logic [XLEN-1:0]  wb_data,
    input  logic             wb_ack,
    output logic [CNT_W-1:0] outstanding,
    output logic             orphan_err,
    output logic             overflow_err
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_FULL  = CNT_W'(DEPTH);

    logic [ID_W-1:0]    r_id_mem  [DEPTH];
    logic [XLEN-1:0]    r_res_mem [DEPTH];
    logic [c_PTR_W-1:0] r_id_wr;
    logic [c_PTR_W-1:0] r_id_rd;
    logic [c_PTR_W-1:0] r_res_wr;
    logic [c_PTR_W-1:0] r_res_rd;
    logic [CNT_W-1:0]   r_id_count;
    logic [CNT_W-1:0]   r_res_count;
    logic               r_orphan;
    logic               r_overflow;

    logic w_pop;
    logic w_id_push;
    logic w_res_push;
    logic w_res_drop;
    logic w_orphan;

    assign wb_valid     = (r_id_count != '0) && (r_res_count != '0);
    assign issue_ready  = (r_id_count != c_FULL);
    assign wb_id        = r_id_mem[r_id_rd];
    assign wb_data      = r_res_mem[r_res_rd];
    assign outstanding  = r_id_count;
    assign orphan_err   = r_orphan;
    assign overflow_err = r_overflow;

    assign w_pop      = wb_valid && wb_ack;
    assign w_id_push  = issue_valid && issue_ready;
    // A full result queue still accepts when the head leaves in the same cycle.
    assign w_res_drop = result_valid && (r_res_count == c_FULL) && !w_pop;
    assign w_res_push = result_valid && !w_res_drop;
    assign w_orphan   = result_valid && ((r_id_count - CNT_W'(w_pop)) == '0) && !w_id_push;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_id_wr     <= '0;
            r_id_rd     <= '0;
            r_res_wr    <= '0;
            r_res_rd    <= '0;
            r_id_count  <= '0;
            r_res_count <= '0;
        end else begin
            if (w_id_push) begin
                r_id_wr <= r_id_wr + c_PTR_W'(1);
            end
            if (w_res_push) begin
                r_res_wr <= r_res_wr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_id_rd  <= r_id_rd + c_PTR_W'(1);
                r_res_rd <= r_res_rd + c_PTR_W'(1);
            end
            r_id_count  <= r_id_count + CNT_W'(w_id_push) - CNT_W'(w_pop);
            r_res_count <= r_res_count + CNT_W'(w_res_push) - CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (w_id_push) begin
                r_id_mem[r_id_wr] <= issue_id;
            end
            if (w_res_push) begin
                r_res_mem[r_res_wr] <= result_data;
            end
        end
    end

    // Sticky flags survive flush; a result lost to flush raises nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_orphan   <= 1'b0;
            r_overflow <= 1'b0;
        end else if (!flush) begin
            if (w_orphan) begin
                r_orphan <= 1'b1;
            end
            if (w_res_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rca_result_collector.sv
// ============================================================================
// Module   : tb_rca_result_collector
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            random traffic against a queue-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rca_result_collector;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam int ID_W  = 3;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             issue_valid;
    logic [ID_W-1:0]  issue_id;
    logic             issue_ready;
    logic             result_valid;
    logic [XLEN-1:0]  result_data;
    logic             wb_valid;
    logic [ID_W-1:0]  wb_id;
    logic [XLEN-1:0]  wb_data;
    logic             wb_ack;
    logic [CNT_W-1:0] outstanding;
    logic             orphan_err;
    logic             overflow_err;

    rca_result_collector #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .ID_W  (ID_W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_id     (issue_id),
        .issue_ready  (issue_ready),
        .result_valid (result_valid),
        .result_data  (result_data),
        .wb_valid     (wb_valid),
        .wb_id        (wb_id),
        .wb_data      (wb_data),
        .wb_ack       (wb_ack),
        .outstanding  (outstanding),
        .orphan_err   (orphan_err),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain queues plus sticky flags.
    int          m_id_q[$];
    logic [31:0] m_res_q[$];
    bit          m_orphan  = 1'b0;
    bit          m_ovf     = 1'b0;
    bit          m_known   = 1'b0;

    typedef struct {
        bit          iv;
        logic [2:0]  iid;
        bit          rv;
        logic [31:0] rd;
        bit          ack;
        bit          ev;
        logic [2:0]  eid;
        logic [31:0] ed;
        logic [3:0]  eout;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, compare against model, update model after the edge.
    task automatic cycle(input bit r, input bit f, input bit iv, input logic [ID_W-1:0] iid,
                         input bit rv, input logic [XLEN-1:0] rd, input bit ack);
        bit exp_v;
        int pop;
        bit idpush;
        bit drop;
        @(negedge clk);
        rst          = r;
        flush        = f;
        issue_valid  = iv;
        issue_id     = iid;
        result_valid = rv;
        result_data  = rd;
        wb_ack       = ack;
        exp_v = (m_id_q.size() != 0) && (m_res_q.size() != 0);
        if (m_known) begin
            check("wb_valid", wb_valid, exp_v);
            check("issue_ready", issue_ready, m_id_q.size() != DEPTH);
            check("outstanding", outstanding, m_id_q.size());
            check("orphan_err", orphan_err, m_orphan);
            check("overflow_err", overflow_err, m_ovf);
            if (exp_v) begin
                check("wb_id", wb_id, m_id_q[0]);
                check("wb_data", wb_data, m_res_q[0]);
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_id_q.delete();
            m_res_q.delete();
            m_orphan = 1'b0;
            m_ovf    = 1'b0;
            m_known  = 1'b1;
        end else if (f) begin
            m_id_q.delete();
            m_res_q.delete();
        end else begin
            pop    = (exp_v && ack) ? 1 : 0;
            idpush = iv && (m_id_q.size() < DEPTH);
            if (rv && (m_id_q.size() - pop) == 0 && !idpush) m_orphan = 1'b1;
            drop = rv && (m_res_q.size() == DEPTH) && (pop == 0);
            if (drop) m_ovf = 1'b1;
            if (pop != 0) begin
                void'(m_id_q.pop_front());
                void'(m_res_q.pop_front());
            end
            if (idpush) m_id_q.push_back(int'(iid));
            if (rv && !drop) m_res_q.push_back(rd);
        end
    endtask

    task automatic idle(input bit ack);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, ack);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    vec_t tbl[6];

    initial begin
        rst = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_id = '0;
        result_valid = 1'b0; result_data = '0; wb_ack = 1'b0;

        do_reset();
        do_reset();
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_issue_ready", issue_ready, 1'b1);
        check("rst_outstanding", outstanding, 0);
        check("rst_orphan", orphan_err, 1'b0);
        check("rst_overflow", overflow_err, 1'b0);

        // Basic pairing: expected columns are the outputs seen before each row's edge.
        tbl[0] = '{1, 3'd2, 0, 32'h00, 1, 0, 3'd0, 32'h00, 4'd0};
        tbl[1] = '{1, 3'd5, 1, 32'h11, 1, 0, 3'd0, 32'h00, 4'd1};
        tbl[2] = '{1, 3'd7, 1, 32'h22, 1, 1, 3'd2, 32'h11, 4'd2};
        tbl[3] = '{0, 3'd0, 1, 32'h33, 1, 1, 3'd5, 32'h22, 4'd2};
        tbl[4] = '{0, 3'd0, 0, 32'h00, 1, 1, 3'd7, 32'h33, 4'd1};
        tbl[5] = '{0, 3'd0, 0, 32'h00, 1, 0, 3'd0, 32'h00, 4'd0};
        for (int i = 0; i < 6; i++) begin
            check("tbl_wb_valid", wb_valid, tbl[i].ev);
            check("tbl_outstanding", outstanding, tbl[i].eout);
            if (tbl[i].ev) begin
                check("tbl_wb_id", wb_id, tbl[i].eid);
                check("tbl_wb_data", wb_data, tbl[i].ed);
            end
            cycle(1'b0, 1'b0, tbl[i].iv, tbl[i].iid, tbl[i].rv, tbl[i].rd, tbl[i].ack);
        end

        // Stall: head must hold while unacknowledged.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, ID_W'(i + 1), 1'b1, 32'hA0 + i, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("stall_wb_valid", wb_valid, 1'b1);
            check("stall_wb_id", wb_id, 3'd1);
            check("stall_wb_data", wb_data, 32'hA0);
            idle(1'b0);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("stall_drained", wb_valid, 1'b0);

        // Full ID queue.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, ID_W'(i), 1'b0, '0, 1'b0);
        check("full_issue_ready", issue_ready, 1'b0);
        check("full_outstanding", outstanding, 8);
        cycle(1'b0, 1'b0, 1'b1, 3'd6, 1'b0, '0, 1'b0);
        check("full_ninth_ignored", outstanding, 8);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h55, 1'b0);
        check("full_still_blocked", issue_ready, 1'b0);
        idle(1'b1);
        check("full_ready_again", issue_ready, 1'b1);

        // Overflow: ninth result dropped while nothing drains.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, ID_W'(i), 1'b0, '0, 1'b0);
        for (int i = 1; i <= 9; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, i, 1'b0);
        check("ovf_flag", overflow_err, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            check("ovf_drain_data", wb_data, i);
            idle(1'b1);
        end
        check("ovf_drain_empty", wb_valid, 1'b0);

        // Overflow avoided: pop in the ninth-result cycle makes room.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, ID_W'(i), 1'b0, '0, 1'b0);
        for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, i, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h9, 1'b1);
        check("noovf_flag", overflow_err, 1'b0);
        for (int i = 0; i < 7; i++) idle(1'b1);
        cycle(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, '0, 1'b0);
        check("noovf_ninth_data", wb_data, 32'h9);

        // Orphan result waits for its ID.
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hAB, 1'b0);
        check("orphan_flag", orphan_err, 1'b1);
        check("orphan_no_valid", wb_valid, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 3'd4, 1'b0, '0, 1'b0);
        check("orphan_valid", wb_valid, 1'b1);
        check("orphan_id", wb_id, 3'd4);
        check("orphan_data", wb_data, 32'hAB);
        idle(1'b1);

        // Flush keeps sticky errors; reset clears them.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, ID_W'(i), 1'b1, 32'hC0 + i, 1'b0);
        check("pre_flush_outstanding", outstanding, 4);
        cycle(1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 32'hEE, 1'b1);
        check("flush_wb_valid", wb_valid, 1'b0);
        check("flush_outstanding", outstanding, 0);
        check("flush_keeps_orphan", orphan_err, 1'b1);
        do_reset();
        check("rst_clears_orphan", orphan_err, 1'b0);
        check("rst_clears_overflow", overflow_err, 1'b0);
        check("rst_issue_ready2", issue_ready, 1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 255) == 0, $urandom_range(0, 63) == 0,
                  $urandom_range(0, 1) == 1, ID_W'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 4, $urandom, $urandom_range(0, 9) < 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rca_result_collector.md
# rca_result_collector

Downstream stage of a reconfigurable-grid slot. Takes the slot's unacknowledged result stream (data + one-cycle valid, no backpressure) and pairs each result, in order, with the Taiga instruction ID recorded at issue. Presents ID-tagged results to the Taiga writeback port over a valid/ack handshake. Buffers both IDs and results so slot latency and writeback stalls are decoupled.

## Interface
- XLEN, 32, result data width
- DEPTH, 8, entries in each of the ID queue and the result queue; power of two, at least 2
- ID_W, 3, instruction ID width (log2 of MAX_IDS)
- CNT_W, $clog2(DEPTH+1), width of the occupancy count
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous clear of both queues
- issue_valid  input  1  RCA instruction issued this cycle
- issue_id  input  ID_W  ID of issued instruction
- issue_ready  output  1  ID queue can accept an issue this cycle
- result_valid  input  1  slot result valid (single-cycle pulse per result)
- result_data  input  XLEN  slot result
- wb_valid  output  1  tagged result available
- wb_id  output  ID_W  ID at head of ID queue
- wb_data  output  XLEN  result at head of result queue
- wb_ack  input  1  writeback consumed head this cycle
- outstanding  output  CNT_W  IDs issued but not yet written back
- orphan_err  output  1  sticky; a result was received while the ID queue would be empty
- overflow_err  output  1  sticky; a result was dropped because the result queue was full

## Operation
- Two circular FIFOs, each DEPTH deep, with registered storage, read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, and a count register of CNT_W bits.
- ID push = issue_valid && issue_ready. issue_ready = (id_count != DEPTH). A same-cycle pop does not raise issue_ready. issue_valid while !issue_ready is ignored.
- Result push = result_valid && !drop. The result is dropped when result_count == DEPTH && !pop; this sets overflow_err. A push with a same-cycle pop on a full queue is accepted.
- Orphan check: if result_valid arrives while (id_count - pop) == 0 and there is no same-cycle ID push, set orphan_err. The result is still queued.
- wb_valid = (id_count != 0) && (result_count != 0).
- wb_id and wb_data are combinational reads of the queue heads.
- pop = wb_valid && wb_ack. A pop removes one entry from both queues. wb_ack while !wb_valid is ignored.
- Counts: count_next = count + push - pop. Push and pop in the same cycle leave the count unchanged.
- outstanding = id_count.
- flush zeroes both pointer pairs and both counts. Any push or pop in the flush cycle is discarded. Error flags are not cleared by flush.
- Error flags are cleared only by rst.

## Timing
- Reset values: wb_valid 0, issue_ready 1, outstanding 0, orphan_err 0, overflow_err 0. wb_id and wb_data are don't-care while wb_valid is 0.
- Issue at cycle N is reflected in outstanding at N+1.
- Result latency: result_valid at cycle N, with its ID already queued, gives wb_valid at N+1. There is no combinational path from result_valid or issue_valid to wb_valid.
- Ack at cycle N: the next head, if any, is presented at N+1. Back-to-back acks sustain 1 result/cycle.
- wb_id and wb_data must stay stable while wb_valid && !wb_ack.
- Error flags assert in the cycle after the offending event.
- rst or flush mid-operation: all queues are empty from the next cycle. A result_valid arriving in the rst/flush cycle is lost and raises no error.

## Test plan
- Basic pairing: issue IDs 2, 5, 7; results 0x11, 0x22, 0x33 with wb_ack held 1 -> writeback (2,0x11), (5,0x22), (7,0x33) on consecutive cycles; outstanding returns to 0.
- Stall: 3 issues and 3 results with wb_ack=0 for 10 cycles -> wb_valid=1, head (ID,data) held stable every cycle; then wb_ack=1 -> drains in 3 cycles.
- Full ID queue: 8 issues with no results -> issue_ready=0 and outstanding=8; a 9th issue is ignored; one result plus ack -> issue_ready=1 next cycle.
- Overflow: 8 IDs queued, wb_ack=0, 9 results 0x1..0x9 -> overflow_err=1; drain yields 0x1..0x8 only. Repeat with wb_ack pulsed in the 9th-result cycle -> 0x9 accepted, no error.
- Orphan: result 0xAB with no issue -> orphan_err=1 next cycle, wb_valid stays 0. Issue ID 4 -> (4,0xAB) presented.
- Flush and reset: 4 entries queued, pulse flush -> wb_valid=0 and outstanding=0 next cycle, with prior errors retained. Pulse rst -> all errors 0 and issue_ready=1.
